// File: rtl/pwm_ctrl_pkg.sv
// Shared constants and FSM encoding for the PWM ramp controller and its frame timer.
// Latency: n/a; backpressure: n/a.
package pwm_ctrl_pkg;

  localparam int PWM_W          = 8;
  localparam int PWM_DWELL_W    = 4;
  localparam int PWM_RST_PERIOD = 255;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } state_e;

endpackage

// File: rtl/pwm_frame_timer.sv
// Frame counter (period+2 clocks per frame) with a shadow period that goes live on the first tick after a load.
// Latency: load visible on the next frame_tick; backpressure: none, a new load simply overwrites the shadow.
module pwm_frame_timer
  import pwm_ctrl_pkg::*;
#(
  parameter int W          = PWM_W,
  parameter int RST_PERIOD = PWM_RST_PERIOD
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_vld,
  input  logic [W-1:0] load_period,
  output logic [W-1:0] period,
  output logic         frame_tick
);

  logic [W:0]   frame_cnt;
  logic [W:0]   frame_last;
  logic [W-1:0] shadow_period;
  logic         load_pend;

  // Extra bit keeps period=2^W-1 from wrapping the terminal count.
  assign frame_last = {1'b0, period} + (W+1)'(1);
  assign frame_tick = (frame_cnt == frame_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt     <= '0;
      period        <= W'(RST_PERIOD);
      shadow_period <= W'(RST_PERIOD);
      load_pend     <= 1'b0;
    end else begin
      frame_cnt <= frame_tick ? '0 : frame_cnt + (W+1)'(1);
      // A tick in the load cycle itself must not promote the shadow.
      if (load_vld) begin
        shadow_period <= load_period;
        load_pend     <= 1'b1;
      end else if (frame_tick && load_pend) begin
        period    <= shadow_period;
        load_pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Ramp sequencer for the PWM generator: slews pulse_width toward a target one step per frame; optional PWM_RAMP_DWELL_EN.
// Latency: first step on the first frame_tick after accept; backpressure: cmd_ready low while ramping or in estop.
module pwm_ramp_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int W          = PWM_W,
  parameter int DWELL_W    = PWM_DWELL_W,
  parameter int RST_PERIOD = PWM_RST_PERIOD
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [W-1:0]       cmd_period,
  input  logic [W-1:0]       cmd_target,
  input  logic [W-1:0]       cmd_step,
`ifdef PWM_RAMP_DWELL_EN
  input  logic [DWELL_W-1:0] cmd_dwell,
`endif
  input  logic               estop,
  output logic [W-1:0]       period,
  output logic [W-1:0]       pulse_width,
  output logic               frame_tick,
  output logic               busy,
  output logic               done
);

  state_e       state;
  logic [W-1:0] target_q;
  logic [W-1:0] step_q;
  logic [W-1:0] target_eff;
  logic [W-1:0] step_eff;
  logic [W-1:0] gap;
  logic         accept;
  logic         step_en;

  assign cmd_ready = (state == ST_IDLE) && !estop;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state == ST_RAMP);

  // cmd_target > cmd_period implies cmd_period < 2^W-1, so period+1 cannot wrap here.
  assign target_eff = (cmd_target <= cmd_period) ? cmd_target : cmd_period + W'(1);
  assign step_eff   = (cmd_step == '0) ? W'(1) : cmd_step;
  assign gap        = (target_q > pulse_width) ? target_q - pulse_width
                                               : pulse_width - target_q;

  pwm_frame_timer #(
    .W          (W),
    .RST_PERIOD (RST_PERIOD)
  ) u_frame_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_vld    (accept),
    .load_period (cmd_period),
    .period      (period),
    .frame_tick  (frame_tick)
  );

`ifdef PWM_RAMP_DWELL_EN
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] dwell_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_q   <= '0;
      dwell_cnt <= '0;
    end else if (accept) begin
      dwell_q   <= cmd_dwell;
      dwell_cnt <= '0;
    end else if (frame_tick && (state == ST_RAMP)) begin
      dwell_cnt <= (dwell_cnt == dwell_q) ? '0 : dwell_cnt + DWELL_W'(1);
    end
  end

  assign step_en = frame_tick && (state == ST_RAMP) && (dwell_cnt == dwell_q);
`else
  logic unused_dwell;
  assign unused_dwell = |DWELL_W;
  assign step_en      = frame_tick && (state == ST_RAMP);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      pulse_width <= '0;
      target_q    <= '0;
      step_q      <= W'(1);
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (estop) begin
        state       <= ST_IDLE;
        pulse_width <= '0;
      end else if (accept) begin
        target_q <= target_eff;
        step_q   <= step_eff;
        state    <= ST_RAMP;
      end else if (step_en) begin
        // Snap to target when within one step, so there is never an overshoot or wrap.
        if (gap <= step_q) begin
          pulse_width <= target_q;
          state       <= ST_IDLE;
          done        <= 1'b1;
        end else if (target_q > pulse_width) begin
          pulse_width <= pulse_width + step_q;
        end else begin
          pulse_width <= pulse_width - step_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Self-checking bench for pwm_ramp_ctrl: directed cases plus randomized commands against a step-list model.
// Build with PWM_RAMP_DWELL_EN defined to also exercise the dwell path.
module tb_pwm_ramp_ctrl;

  localparam int W = 8;
`ifdef PWM_RAMP_DWELL_EN
  localparam int DWELL_MAX = 2;
`else
  localparam int DWELL_MAX = 0;
`endif

  logic         clk;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [W-1:0] cmd_period;
  logic [W-1:0] cmd_target;
  logic [W-1:0] cmd_step;
`ifdef PWM_RAMP_DWELL_EN
  logic [3:0]   cmd_dwell;
`endif
  logic         estop;
  logic [W-1:0] period;
  logic [W-1:0] pulse_width;
  logic         frame_tick;
  logic         busy;
  logic         done;

  int checks    = 0;
  int failures  = 0;
  int cyc       = 0;
  int done_seen = 0;
  int m_width;
  int m_period;

  pwm_ramp_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_period  (cmd_period),
    .cmd_target  (cmd_target),
    .cmd_step    (cmd_step),
`ifdef PWM_RAMP_DWELL_EN
    .cmd_dwell   (cmd_dwell),
`endif
    .estop       (estop),
    .period      (period),
    .pulse_width (pulse_width),
    .frame_tick  (frame_tick),
    .busy        (busy),
    .done        (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;
  always @(posedge clk) if (done === 1'b1) done_seen++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_tick(output int tc);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_tick !== 1'b1 && n < 600);
    chk("frame_tick_seen", frame_tick, 1);
    tc = cyc;
  endtask

  task automatic check_reset_state(input string pfx);
    chk({pfx, "_period"}, period, 255);
    chk({pfx, "_width"}, pulse_width, 0);
    chk({pfx, "_ready"}, cmd_ready, 1);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_done"}, done, 0);
    chk({pfx, "_tick"}, frame_tick, 0);
  endtask

  task automatic drive_cmd(input int p, input int t, input int s, input int d);
    cmd_valid  = 1'b1;
    cmd_period = W'(p);
    cmd_target = W'(t);
    cmd_step   = W'(s);
`ifdef PWM_RAMP_DWELL_EN
    cmd_dwell  = 4'(d);
`else
    if (d != 0) $display("note: dwell %0d ignored without dwell build", d);
`endif
  endtask

  // Model: list of widths the ramp must visit, derived from target/step rules.
  task automatic follow_ramp(input int p, input int t, input int s, input int d,
                             input int acc_cyc, input int exact_lat);
    int tg, st, w, tc, prev_tc, d0, lat;
    int exp_q[$];
    tg = (t <= p) ? t : p + 1;
    st = (s == 0) ? 1 : s;
    w  = m_width;
    forever begin
      if (((tg > w) ? tg - w : w - tg) <= st) begin
        exp_q.push_back(tg);
        break;
      end
      w = (tg > w) ? w + st : w - st;
      exp_q.push_back(w);
    end
    d0 = done_seen;
    prev_tc = 0;
    foreach (exp_q[i]) begin
      for (int k = 0; k <= d; k++) begin
        wait_tick(tc);
        if (i == 0 && k == 0) begin
          lat = tc - acc_cyc;
          if (exact_lat != 0) chk("first_tick_latency", lat, m_period + 2);
          else chk("first_tick_in_window", (lat >= 1 && lat <= m_period + 2), 1);
        end
      end
      if (i > 0) chk("step_gap", tc - prev_tc, (d + 1) * (p + 2));
      prev_tc = tc;
      @(negedge clk);
      chk("width", pulse_width, exp_q[i]);
      chk("period", period, p);
      chk("done_at_step", done, (i == exp_q.size() - 1));
      chk("busy_at_step", busy, (i != exp_q.size() - 1));
    end
    @(posedge clk);
    #1;
    chk("done_count", done_seen - d0, 1);
    chk("done_one_cycle", done, 0);
    chk("ready_after_ramp", cmd_ready, 1);
    m_width  = tg;
    m_period = p;
  endtask

  task automatic run_cmd(input int p, input int t, input int s, input int d, input int align);
    int tc, acc_cyc;
    if (align != 0) wait_tick(tc);
    chk("ready_before_cmd", cmd_ready, 1);
    drive_cmd(p, t, s, d);
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("busy_after_accept", busy, 1);
    chk("ready_after_accept", cmd_ready, 0);
    chk("period_held_until_tick", period, m_period);
    follow_ramp(p, t, s, d, acc_cyc, align);
  endtask

  initial begin
    int tc, c0, d0, acc_cyc;
    int p, t, s, d, al;
    rst_n = 1'b0;
    estop = 1'b0;
    m_width  = 0;
    m_period = 255;
    drive_cmd(0, 0, 0, 0);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    c0 = cyc;
    #1;
    check_reset_state("reset");
    wait_tick(tc);
    chk("first_tick_clock", tc - c0 + 1, 257);

    run_cmd(10, 6, 2, 0, 0);
    run_cmd(10, 1, 4, 0, 1);
    run_cmd(100, 200, 255, 0, 0);
    run_cmd(100, 0, 255, 0, 0);
    run_cmd(10, 3, 0, 0, 1);
`ifdef PWM_RAMP_DWELL_EN
    run_cmd(10, 4, 2, 2, 0);
`endif
    run_cmd(10, 0, 255, 0, 0);

    // Emergency stop in the middle of a ramp, with a command held across it.
    chk("ready_before_estop_cmd", cmd_ready, 1);
    drive_cmd(10, 8, 2, 0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_tick(tc);
    @(negedge clk);
    chk("estop_ramp_w1", pulse_width, 2);
    wait_tick(tc);
    @(negedge clk);
    chk("estop_ramp_w2", pulse_width, 4);
    d0 = done_seen;
    estop = 1'b1;
    drive_cmd(12, 5, 3, 0);
    @(posedge clk);
    #1;
    chk("estop_width", pulse_width, 0);
    chk("estop_busy", busy, 0);
    chk("estop_ready", cmd_ready, 0);
    chk("estop_period", period, 10);
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      chk("estop_hold_width", pulse_width, 0);
      chk("estop_hold_busy", busy, 0);
    end
    estop = 1'b0;
    #1;
    chk("ready_after_estop", cmd_ready, 1);
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("accept_after_estop", busy, 1);
    chk("no_done_on_estop", done_seen - d0, 0);
    m_width  = 0;
    m_period = 10;
    follow_ramp(12, 5, 3, 0, acc_cyc, 0);

    // Asynchronous reset in the middle of a ramp.
    drive_cmd(20, 9, 1, 0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_tick(tc);
    @(negedge clk);
    chk("pre_reset_width", pulse_width, 6);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("midramp_reset");
    @(negedge clk);
    rst_n = 1'b1;
    m_width  = 0;
    m_period = 255;

    for (int n = 0; n < 6; n++) begin
      p  = $urandom_range(2, 20);
      t  = $urandom_range(0, 255);
      s  = $urandom_range(0, 6);
      d  = $urandom_range(0, DWELL_MAX);
      al = $urandom_range(0, 1);
      run_cmd(p, t, s, d, al);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_ramp_ctrl.md
# pwm_ramp_ctrl

Controller that sequences the 8-bit PWM generator's `period` and `pulse_width` inputs. It accepts ramp commands over a valid/ready handshake and applies period changes only at frame boundaries. It slews the pulse width toward a target in bounded steps, one step per frame, and provides an emergency stop that forces the output low. It sits between the register/command interface and the PWM generator, and drives the generator's configuration inputs directly.

## Interface
- `W`, 8, width of period/pulse-width datapath
- `DWELL_W`, 4, width of dwell count (used only with the dwell feature)
- `RST_PERIOD`, 255, period value driven out of reset

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  controller can accept a command
- `cmd_period`  in  W  new PWM period
- `cmd_target`  in  W  final pulse width
- `cmd_step`  in  W  maximum change per step; 0 treated as 1
- `cmd_dwell`  in  DWELL_W  extra frames per step (present only with `PWM_RAMP_DWELL_EN`)
- `estop`  in  1  emergency stop, level
- `period`  out  W  to PWM generator
- `pulse_width`  out  W  to PWM generator
- `frame_tick`  out  1  high on the last clock of each PWM frame
- `busy`  out  1  ramp in progress
- `done`  out  1  one-cycle pulse when the target is reached

## Operation
- Reset values: `period`=RST_PERIOD, `pulse_width`=0, `cmd_ready`=1, `busy`=0, `done`=0, `frame_tick`=0, frame counter=0, state IDLE.
- PWM frame length is `period`+2 clocks. The frame counter counts 0..`period`+1. `frame_tick` is high when the count equals `period`+1. The counter runs in every state. `period`+1 is computed in W+1 bits, so 255 gives a 257-clock frame.
- States are IDLE and RAMP.
- In IDLE, `cmd_ready` = !`estop`. A handshake (`cmd_valid`&&`cmd_ready`) performs the following:
  - latches `cmd_period` into the shadow period
  - latches the effective target = min(`cmd_target`, `cmd_period`+1), saturated at 2^W−1
  - latches the step
  - enters RAMP with `busy`=1 and `cmd_ready`=0
- The shadow period is copied to `period` on the first `frame_tick` strictly after the accept cycle.
- In RAMP, on each qualifying `frame_tick`:
  - if |target−`pulse_width`| ≤ step, `pulse_width` is set to target and the state returns to IDLE.
  - otherwise `pulse_width` moves by ±step toward the target.
  - arithmetic is in W+1 bits; no wrap, no overshoot.
- A target equal to the current width completes on the first qualifying tick with no change.
- `done` pulses one cycle, registered in the cycle after the final-step `frame_tick`. `busy` falls and `cmd_ready` rises in that same cycle.
- `estop`=1 at a clock edge has the following effect:
  - `pulse_width` is set to 0 and the state goes to IDLE, with `busy`=0.
  - any ramp is abandoned and no `done` is generated.
  - `period` and the pending shadow load are unaffected.
  - `estop` overrides a simultaneous command accept, since `cmd_ready` is 0.
- Asserting `rst_n` mid-ramp returns all outputs to their reset values immediately.

## Timing
- Command-to-first-step latency: the first `frame_tick` after accept, i.e. 1 to `period_old`+2 clocks.
- When the accept cycle coincides with `frame_tick`, that tick neither loads the period nor counts as a step.
- The step and period update occur on the same `frame_tick`. The new `period` is visible together with the first step width.
- `estop` takes effect on the next rising edge (1-cycle latency). `pulse_width` stays 0 while `estop` is high.

## Configuration
- `PWM_RAMP_DWELL_EN` defined:
  - `cmd_dwell` port exists and is latched at accept.
  - a step is applied only every (`cmd_dwell`+1) `frame_tick`s, using a dwell counter reset at accept.
- `PWM_RAMP_DWELL_EN` undefined:
  - port and counter are absent.
  - a step is applied on every `frame_tick` after accept.

## Structure
- Shared package `pwm_ctrl_pkg` holds:
  - the state enum (ST_IDLE, ST_RAMP)
  - the default W, DWELL_W and RST_PERIOD constants
- One sub-module, `pwm_frame_timer`, holds:
  - the frame counter
  - the shadow/active period registers
  - `frame_tick` generation
- The step/FSM logic stays in the top.

## Test plan
- Reset release: `period`=255, `pulse_width`=0, `cmd_ready`=1, `busy`=0; first `frame_tick` at clock 257.
- Command period=10, target=6, step=2 from width 0: `pulse_width` goes 2, 4, 6 on successive ticks spaced 12 clocks apart. `done` pulses once, one cycle after the third tick. `busy`=0 afterwards.
- From width 6, target=1, step=4: widths 2 then 1; no underflow; `done` once.
- Command period=100, target=200, step=255: `pulse_width`=101 on the first tick; step=0 command from 0 to 3 gives 1, 2, 3.
- `estop` asserted mid-ramp at width 4: width is 0 at the next edge, `busy`=0, no `done`. A `cmd_valid` held during `estop` is not accepted; it is accepted in the cycle after `estop` deasserts.
- With `PWM_RAMP_DWELL_EN`, dwell=2, period=10, target=4, step=2: widths change on ticks 3 and 6 (every 36 clocks).
